// File: rtl/complex_invert_serial_pkg.sv
// Shared types for the serial complex reciprocal.
// Holds the controller state encoding.
package complex_invert_serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAG,
    S_DIV_RE,
    S_DIV_IM,
    S_OUT
  } state_t;

endpackage

// File: rtl/complex_invert_serial_udiv.sv
// Unsigned restoring divider, one quotient bit per cycle.
// quot/rem carry the final result combinationally in the done cycle.
module serial_udiv #(
  parameter int NUM_W = 46,
  parameter int DEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quot,
  output logic [DEN_W-1:0] rem
);

  localparam int CW = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_q, rem_d;
  logic [NUM_W-1:0] quot_q, quot_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [DEN_W:0]   sh;
  logic [DEN_W:0]   diff;
  logic             ge;
  logic [DEN_W-1:0] rem_nx;
  logic [NUM_W-1:0] quot_nx;

  always_comb begin
    sh      = {rem_q, quot_q[NUM_W-1]};
    diff    = sh - {1'b0, den_q};
    ge      = (sh >= {1'b0, den_q});
    rem_nx  = ge ? diff[DEN_W-1:0] : sh[DEN_W-1:0];
    quot_nx = {quot_q[NUM_W-2:0], ge};
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign quot = quot_nx;
  assign rem  = rem_nx;

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = '0;
      quot_d = num;
      den_d  = den;
      cnt_d  = CW'(NUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = rem_nx;
      quot_d = quot_nx;
      cnt_d  = cnt_q - CW'(1);
      busy_d = (cnt_q != CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/complex_invert_serial.sv
// Streaming 1/(a+bi) = (a-bi)/(a^2+b^2) with one shared serial divider.
// Results are rounded half-up on magnitude and saturated to WIDTH bits.
module complex_invert_serial
  import complex_invert_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 2 * (WIDTH - 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [2*WIDTH-1:0] i_tdata,
  input  logic               i_tlast,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [2*WIDTH-1:0] o_tdata,
  output logic               o_tlast,
  output logic               o_tuser,
  output logic               o_tvalid,
  input  logic               o_tready
);

  localparam int N = WIDTH + SHIFT;
  localparam int D = 2 * WIDTH;
  localparam logic [N:0] LIM =
    {{(N-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic [D-1:0]     mag_q, mag_d;
  logic             last_q, last_d;
  logic             user_q, user_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [D-1:0]     mag;
  logic             div_start, div_busy, div_done;
  logic [N-1:0]     div_num, quot;
  logic [D-1:0]     div_den, rem;

  function automatic logic [WIDTH-1:0] cond_q(
    input logic [N-1:0] q,
    input logic [D-1:0] r,
    input logic [D-1:0] m,
    input logic         neg
  );
    logic [N:0] mr;
    mr = {1'b0, q} + {{N{1'b0}}, ({r, 1'b0} >= {1'b0, m})};
    if (neg)
      cond_q = (mr >= LIM) ? {1'b1, {(WIDTH-1){1'b0}}}
                           : -mr[WIDTH-1:0];
    else
      cond_q = (mr >= LIM) ? {1'b0, {(WIDTH-1){1'b1}}}
                           : mr[WIDTH-1:0];
  endfunction

  // |-2^(W-1)| wraps to 2^(W-1), exact as an unsigned W-bit value.
  assign abs_a = a_q[WIDTH-1] ? -a_q : a_q;
  assign abs_b = b_q[WIDTH-1] ? -b_q : b_q;
  assign mag   = D'(abs_a) * D'(abs_a) + D'(abs_b) * D'(abs_b);

  assign div_den = (state_q == S_MAG) ? mag : mag_q;

  serial_udiv #(
    .NUM_W(N),
    .DEN_W(D)
  ) u_div (
    .clk  (clk),
    .reset(reset | clear),
    .start(div_start),
    .num  (div_num),
    .den  (div_den),
    .busy (div_busy),
    .done (div_done),
    .quot (quot),
    .rem  (rem)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    re_d      = re_q;
    im_d      = im_q;
    mag_d     = mag_q;
    last_d    = last_q;
    user_d    = user_q;
    div_start = 1'b0;
    div_num   = {abs_a, {SHIFT{1'b0}}};
    unique case (state_q)
      S_IDLE: begin
        if (i_tvalid) begin
          a_d     = i_tdata[2*WIDTH-1:WIDTH];
          b_d     = i_tdata[WIDTH-1:0];
          last_d  = i_tlast;
          state_d = S_MAG;
        end
      end
      S_MAG: begin
        mag_d = mag;
        if (mag == '0) begin
          re_d    = '0;
          im_d    = '0;
          user_d  = 1'b1;
          state_d = S_OUT;
        end else begin
          user_d    = 1'b0;
          div_start = 1'b1;
          state_d   = S_DIV_RE;
        end
      end
      S_DIV_RE: begin
        if (div_done) begin
          re_d      = cond_q(quot, rem, mag_q, a_q[WIDTH-1]);
          div_start = 1'b1;
          div_num   = {abs_b, {SHIFT{1'b0}}};
          state_d   = S_DIV_IM;
        end else if (!div_busy) begin
          state_d = S_IDLE;
        end
      end
      S_DIV_IM: begin
        if (div_done) begin
          im_d    = cond_q(quot, rem, mag_q,
                           !b_q[WIDTH-1] && (b_q != '0));
          state_d = S_OUT;
        end else if (!div_busy) begin
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (o_tready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      re_q    <= '0;
      im_q    <= '0;
      mag_q   <= '0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      re_q    <= re_d;
      im_q    <= im_d;
      mag_q   <= mag_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign i_tready = (state_q == S_IDLE);
  assign o_tvalid = (state_q == S_OUT);
  assign o_tdata  = {re_q, im_q};
  assign o_tlast  = last_q;
  assign o_tuser  = user_q;

endmodule
